// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush response controller: sequences MEM-stage SRAM waits and drives freeze/bubble/flush.
// Optional statistics counters are built when STALL_STATS_EN is defined; otherwise they read 0.
module pipeline_stall_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 64,
   parameter int unsigned CNT_WIDTH   = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 hazard_detected,
   input  logic                 branch_taken,
   input  logic                 mem_req,
   input  logic                 mem_ready,
   output logic                 mem_start,
   output logic                 freeze_all,
   output logic                 freeze_if,
   output logic                 bubble,
   output logic                 flush,
   output logic                 timeout_err,
   output logic [CNT_WIDTH-1:0] hazard_stall_cnt,
   output logic [CNT_WIDTH-1:0] mem_stall_cnt,
   output logic [CNT_WIDTH-1:0] flush_cnt
);

   typedef enum logic [1:0] {RUN, MEM_WAIT, RELEASE} state_t;

   localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

   state_t      state, state_nxt;
   logic [15:0] wait_cnt;
   logic        timeout_q;
   logic        timeout_hit;

   always_comb begin
      mem_start   = 1'b0;
      freeze_all  = 1'b0;
      freeze_if   = 1'b0;
      bubble      = 1'b0;
      flush       = 1'b0;
      timeout_hit = 1'b0;
      state_nxt   = state;
      case (state)
         RUN: begin
            if (mem_req) begin
               mem_start  = 1'b1;
               freeze_all = 1'b1;
               freeze_if  = 1'b1;
               state_nxt  = MEM_WAIT;
            end else if (branch_taken) begin
               flush = 1'b1;
            end else if (hazard_detected) begin
               freeze_if = 1'b1;
               bubble    = 1'b1;
            end
         end
         MEM_WAIT: begin
            freeze_all = 1'b1;
            freeze_if  = 1'b1;
            if (mem_ready) begin
               state_nxt = RELEASE;
            end else if (wait_cnt == WAIT_LAST) begin
               timeout_hit = 1'b1;
               state_nxt   = RELEASE;
            end
         end
         RELEASE: begin
            // mem_req still belongs to the departing instruction here, so it must not restart
            state_nxt = RUN;
            if (branch_taken) begin
               flush = 1'b1;
            end else if (hazard_detected) begin
               freeze_if = 1'b1;
               bubble    = 1'b1;
            end
         end
         default: state_nxt = RUN;
      endcase
      if (!rst) begin
         mem_start   = 1'b0;
         freeze_all  = 1'b0;
         freeze_if   = 1'b0;
         bubble      = 1'b0;
         flush       = 1'b0;
         timeout_hit = 1'b0;
         state_nxt   = RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= RUN;
         wait_cnt  <= '0;
         timeout_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == MEM_WAIT) wait_cnt <= wait_cnt + 16'd1;
         else                   wait_cnt <= '0;
         if (timeout_hit) timeout_q <= 1'b1;
      end
   end

   assign timeout_err = timeout_q & rst;

`ifdef STALL_STATS_EN
   logic [CNT_WIDTH-1:0] hazard_q, mem_q, flush_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         hazard_q <= '0;
         mem_q    <= '0;
         flush_q  <= '0;
      end else begin
         if (bubble)     hazard_q <= hazard_q + CNT_WIDTH'(1);
         if (freeze_all) mem_q    <= mem_q + CNT_WIDTH'(1);
         if (flush)      flush_q  <= flush_q + CNT_WIDTH'(1);
      end
   end

   assign hazard_stall_cnt = rst ? hazard_q : '0;
   assign mem_stall_cnt    = rst ? mem_q    : '0;
   assign flush_cnt        = rst ? flush_q  : '0;
`else
   assign hazard_stall_cnt = '0;
   assign mem_stall_cnt    = '0;
   assign flush_cnt        = '0;
`endif

endmodule
